// File: rtl/nibble_packer_4out_if.sv
// Nibble stream in, packed word out, for nibble_packer_4out.
// MAX_NIBBLE exists only when NIBBLE_PACK_MAX_EN is defined.
interface nibble_packer_4out_if #(
   parameter int NUM_NIBBLES = 4
);
   logic [3:0]               NIB_IN;
   logic                     NIB_VALID;
   logic                     NIB_READY;
   logic                     FLUSH;
   logic [4*NUM_NIBBLES-1:0] NIBBLES;
   logic                     WORD_VALID;
   logic                     WORD_READY;
   logic [3:0]               WORD_FILL;
`ifdef NIBBLE_PACK_MAX_EN
   logic [3:0]               MAX_NIBBLE;
`endif

   modport slave (
      input  NIB_IN, NIB_VALID, FLUSH, WORD_READY,
`ifdef NIBBLE_PACK_MAX_EN
      output MAX_NIBBLE,
`endif
      output NIB_READY, NIBBLES, WORD_VALID, WORD_FILL
   );

   modport master (
      output NIB_IN, NIB_VALID, FLUSH, WORD_READY,
`ifdef NIBBLE_PACK_MAX_EN
      input  MAX_NIBBLE,
`endif
      input  NIB_READY, NIBBLES, WORD_VALID, WORD_FILL
   );
endinterface

// File: rtl/nibble_packer_4out.sv
// Packs a valid/ready nibble stream into NUM_NIBBLES-wide words with flush/pad.
// Optional NIBBLE_PACK_MAX_EN adds a registered MAX_NIBBLE of the real nibbles.
module nibble_packer_4out #(
   parameter int         NUM_NIBBLES = 4,
   parameter logic [3:0] PAD_NIBBLE  = 4'h0
) (
   input logic                  CLK,
   input logic                  RESET_L,
   nibble_packer_4out_if.slave  bus
);
   localparam int CW = $clog2(NUM_NIBBLES);

   logic [CW-1:0]                cnt;
   logic [NUM_NIBBLES-1:0][3:0]  acc;
   logic [NUM_NIBBLES-1:0][3:0]  merged;
   logic                         last;
   logic                         free;
   logic                         ready;
   logic                         accept;
   logic                         close;
   logic [3:0]                   fill;

   always_comb begin
      last   = (cnt == CW'(NUM_NIBBLES - 1));
      free   = !bus.WORD_VALID || bus.WORD_READY;
      // Only the final slot and flushes wait for the output register.
      ready  = (!last && !bus.FLUSH) ? 1'b1 : free;
      accept = bus.NIB_VALID && ready;
      close  = free && ((accept && last) || (bus.FLUSH && (cnt != '0 || accept)));
      fill   = 4'(cnt) + 4'(accept);
      merged = '0;
      for (int unsigned i = 0; i < NUM_NIBBLES; i++) begin
         if (i < 32'(cnt))
            merged[i] = acc[i];
         else if (i == 32'(cnt) && accept)
            merged[i] = bus.NIB_IN;
         else
            merged[i] = PAD_NIBBLE;
      end
   end

   assign bus.NIB_READY = ready;

`ifdef NIBBLE_PACK_MAX_EN
   logic [3:0] run_max;
   logic [3:0] next_max;

   always_comb begin
      next_max = (accept && (bus.NIB_IN > run_max)) ? bus.NIB_IN : run_max;
   end

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         run_max        <= '0;
         bus.MAX_NIBBLE <= '0;
      end else if (close) begin
         run_max        <= '0;
         bus.MAX_NIBBLE <= next_max;
      end else if (accept) begin
         run_max        <= next_max;
      end
   end
`endif

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         cnt            <= '0;
         acc            <= '0;
         bus.NIBBLES    <= '0;
         bus.WORD_VALID <= 1'b0;
         bus.WORD_FILL  <= '0;
      end else if (close) begin
         bus.NIBBLES    <= merged;
         bus.WORD_FILL  <= fill;
         bus.WORD_VALID <= 1'b1;
         cnt            <= '0;
         acc            <= '0;
      end else begin
         if (bus.WORD_VALID && bus.WORD_READY)
            bus.WORD_VALID <= 1'b0;
         if (accept) begin
            acc[cnt] <= bus.NIB_IN;
            cnt      <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_nibble_packer_4out.sv
// Scoreboard bench for nibble_packer_4out: directed words plus a short random stream.
module tb_nibble_packer_4out;
   logic CLK = 1'b0;
   logic RESET_L;
   always #5 CLK = ~CLK;

   nibble_packer_4out_if #(.NUM_NIBBLES(4)) bus ();

   nibble_packer_4out #(.NUM_NIBBLES(4), .PAD_NIBBLE(4'h0)) dut (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .bus     (bus)
   );

   typedef struct {
      logic [15:0] w;
      logic [3:0]  fill;
      logic [3:0]  mx;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;
   bit   rnd_ready = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [15:0] w, input logic [3:0] fill, input logic [3:0] mx);
      exp_t e;
      e.w = w; e.fill = fill; e.mx = mx;
      q.push_back(e);
   endtask

   // Present one beat and hold it until the packer takes it (bounded).
   task automatic send(input logic [3:0] n, input logic v, input logic fl);
      bit ok = 1'b0;
      bus.NIB_IN = n; bus.NIB_VALID = v; bus.FLUSH = fl;
      for (int t = 0; t < 200; t++) begin
         @(negedge CLK);
         if (bus.NIB_READY) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++;
         $display("FAIL send_timeout: got NIB_READY=0 expected 1 within 200 cycles");
      end
      @(posedge CLK); #1;
      bus.NIB_VALID = 1'b0; bus.FLUSH = 1'b0;
   endtask

   // Monitor: compare the presented word to the head of the scoreboard.
   always @(negedge CLK) begin
      if (RESET_L && bus.WORD_VALID) begin
         if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_word: got %h expected no word", bus.NIBBLES);
         end else begin
            chk("word", 32'(bus.NIBBLES), 32'(q[0].w));
            chk("fill", 32'(bus.WORD_FILL), 32'(q[0].fill));
`ifdef NIBBLE_PACK_MAX_EN
            chk("max", 32'(bus.MAX_NIBBLE), 32'(q[0].mx));
`endif
            if (bus.WORD_READY) void'(q.pop_front());
         end
      end
   end

   always @(posedge CLK) begin
      if (rnd_ready) begin
         #1;
         bus.WORD_READY = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      logic [3:0]  n [4];
      logic [15:0] w;
      logic [3:0]  mx;
      int unsigned len;

      RESET_L = 1'b0;
      bus.NIB_IN = '0; bus.NIB_VALID = 1'b0; bus.FLUSH = 1'b0; bus.WORD_READY = 1'b1;
      #12;
      chk("rst_nibbles", 32'(bus.NIBBLES), 0);
      chk("rst_valid", 32'(bus.WORD_VALID), 0);
      chk("rst_fill", 32'(bus.WORD_FILL), 0);
      chk("rst_nib_ready", 32'(bus.NIB_READY), 1);
`ifdef NIBBLE_PACK_MAX_EN
      chk("rst_max", 32'(bus.MAX_NIBBLE), 0);
`endif
      @(posedge CLK); #1; RESET_L = 1'b1;

      // Full word, drained immediately; valid lasts one cycle.
      send(4'h1, 1, 0); send(4'h2, 1, 0); send(4'h3, 1, 0);
      push(16'h4321, 4, 4'h4);
      send(4'h4, 1, 0);
      @(negedge CLK); chk("valid_cycle1", 32'(bus.WORD_VALID), 1);
      @(negedge CLK); chk("valid_cycle2", 32'(bus.WORD_VALID), 0);

      // Stalled output: non-final slots fill, final slot waits.
      @(posedge CLK); #1; bus.WORD_READY = 1'b0;
      send(4'h1, 1, 0); send(4'h2, 1, 0); send(4'h3, 1, 0);
      push(16'h4321, 4, 4'h4);
      send(4'h4, 1, 0);
      send(4'h5, 1, 0); send(4'h6, 1, 0); send(4'h7, 1, 0);
      push(16'h8765, 4, 4'h8);
      bus.NIB_IN = 4'h8; bus.NIB_VALID = 1'b1;
      @(negedge CLK); chk("stall_nib_ready", 32'(bus.NIB_READY), 0);
      chk("stall_held", 32'(bus.NIBBLES), 32'h4321);
      @(posedge CLK); #1; bus.WORD_READY = 1'b1;
      @(negedge CLK); chk("release_nib_ready", 32'(bus.NIB_READY), 1);
      @(posedge CLK); #1; bus.NIB_VALID = 1'b0;
      @(negedge CLK); chk("no_bubble_valid", 32'(bus.WORD_VALID), 1);
      chk("no_bubble_word", 32'(bus.NIBBLES), 32'h8765);

      // Flush alone, then an empty flush that must produce nothing.
      @(posedge CLK); #1;
      send(4'h9, 1, 0); send(4'hA, 1, 0);
      push(16'h00A9, 2, 4'hA);
      send(4'h0, 0, 1);
      repeat (2) @(posedge CLK);
      #1; bus.FLUSH = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK); chk("empty_flush_valid", 32'(bus.WORD_VALID), 0);
      end
      @(posedge CLK); #1; bus.FLUSH = 1'b0;

      // Nibble and flush together.
      send(4'hB, 1, 0);
      push(16'h00CB, 2, 4'hC);
      send(4'hC, 1, 1);
      repeat (2) @(posedge CLK); #1;

      // Async reset mid-word.
      send(4'h1, 1, 0); send(4'h2, 1, 0);
      #2; RESET_L = 1'b0; #1;
      chk("rst1_nibbles", 32'(bus.NIBBLES), 0);
      chk("rst1_valid", 32'(bus.WORD_VALID), 0);
      chk("rst1_fill", 32'(bus.WORD_FILL), 0);
      q.delete();
      @(posedge CLK); #1; RESET_L = 1'b1;

      // Async reset while a word is presented.
      bus.WORD_READY = 1'b0;
      send(4'h1, 1, 0); send(4'h2, 1, 0); send(4'h3, 1, 0);
      push(16'h4321, 4, 4'h4);
      send(4'h4, 1, 0);
      chk("pre_rst2_valid", 32'(bus.WORD_VALID), 1);
      #1; RESET_L = 1'b0; #1;
      chk("rst2_nibbles", 32'(bus.NIBBLES), 0);
      chk("rst2_valid", 32'(bus.WORD_VALID), 0);
      chk("rst2_fill", 32'(bus.WORD_FILL), 0);
      q.delete();
      @(posedge CLK); #1; RESET_L = 1'b1; bus.WORD_READY = 1'b1;
      send(4'h1, 1, 0); send(4'h2, 1, 0); send(4'h3, 1, 0);
      push(16'h4321, 4, 4'h4);
      send(4'h4, 1, 0);
      repeat (2) @(posedge CLK); #1;

`ifdef NIBBLE_PACK_MAX_EN
      send(4'h3, 1, 0); send(4'hF, 1, 0); send(4'h1, 1, 0);
      push(16'h71F3, 4, 4'hF);
      send(4'h7, 1, 0);
      send(4'h2, 1, 0);
      push(16'h0052, 2, 4'h5);
      send(4'h5, 1, 1);
      repeat (2) @(posedge CLK); #1;
`endif

      // Random-length words under random back-pressure.
      rnd_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         len = $urandom_range(1, 4);
         w = '0; mx = '0;
         for (int unsigned i = 0; i < len; i++) begin
            n[i] = 4'($urandom_range(0, 15));
            w[i*4 +: 4] = n[i];
            if (n[i] > mx) mx = n[i];
         end
         for (int unsigned i = 0; i < len; i++) begin
            if (i == len - 1) push(w, 4'(len), mx);
            send(n[i], 1, (i == len - 1) && (len < 4));
         end
      end
      rnd_ready = 1'b0;
      @(posedge CLK); #2; bus.WORD_READY = 1'b1;

      repeat (5) @(posedge CLK); #1;
      chk("queue_empty", 32'(q.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
